cpu_bus_bridge: RTL and testbench

//  Memory/peripheral bus bridge downstream of the 6502 core wrapper. Consumes
//  the core's address/data-out/write-enable. Returns read data and the RDY stall signal.

---
 rtl/cpu_bus_bridge.sv | 141 ++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: memory/peripheral bridge behind the 6502 core wrapper.
//
// Decodes the core address into three regions:
//   - on-chip synchronous RAM (zero wait states, 1-cycle read latency)
//   - an I/O page using a req/ack handshake with a timeout
//   - unmapped space (writes dropped, reads return open-bus 8'hFF)
// While an I/O access is outstanding, cpu_rdy is held low to stall the core.
//
// Ports:
//   clk, reset            CPU clock, synchronous active-high reset
//   cpu_a/cpu_do/cpu_we   core address, write data, write enable (cycle n)
//   cpu_di                read data to the core (cycle n+1)
//   cpu_rdy               core RDY; 0 stalls the core
//   ram_addr/wdata/we     RAM write/address port (combinational)
//   ram_rdata             RAM read data, 1-cycle synchronous read
//   io_req/we/addr/wdata  registered I/O request, stable while io_req=1
//   io_rdata/io_ack       I/O completion and read data
//   bus_err               sticky I/O timeout flag, cleared only by reset

module cpu_bus_bridge #(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [3:0]  IO_PAGE    = 4'hD,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_a,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  output logic              cpu_rdy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [11:0]       io_addr,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  input  logic              io_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {StIdle, StIoWait, StIoDone} state_e;
  typedef enum logic [1:0] {SelUnmapped, SelRam, SelIo} sel_e;

  // Counter value seen in the last permitted wait cycle.
  localparam logic [7:0] TimeoutCnt = 8'(IO_TIMEOUT - 1);
  localparam logic [31:0] RamSize   = 32'd1 << RAM_AW;

  state_e      state_q;
  sel_e        rsel_q;
  sel_e        rsel_d;
  logic [7:0]  io_data_q;
  logic [7:0]  wait_cnt_q;
  logic        io_req_q;
  logic        io_we_q;
  logic [11:0] io_addr_q;
  logic [7:0]  io_wdata_q;
  logic        bus_err_q;
  logic        ram_hit;
  logic        io_hit;

  // RAM wins over the I/O page if the windows overlap.
  always_comb begin
    ram_hit = ({16'h0000, cpu_a} < RamSize);
    io_hit  = !ram_hit && (cpu_a[15:12] == IO_PAGE);
    rsel_d  = SelUnmapped;
    if (ram_hit) begin
      rsel_d = SelRam;
    end else if (io_hit) begin
      rsel_d = SelIo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rsel_q     <= SelUnmapped;
      io_data_q  <= 8'hFF;
      wait_cnt_q <= 8'h00;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 12'h000;
      io_wdata_q <= 8'h00;
      bus_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIoDone: begin
          rsel_q <= rsel_d;
          if (io_hit) begin
            io_req_q   <= 1'b1;
            io_we_q    <= cpu_we;
            io_addr_q  <= cpu_a[11:0];
            io_wdata_q <= cpu_do;
            wait_cnt_q <= 8'h00;
            state_q    <= StIoWait;
          end else begin
            state_q <= StIdle;
          end
        end
        StIoWait: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (io_ack) begin
            // An ack in the timeout cycle still wins.
            io_data_q <= io_rdata;
            io_req_q  <= 1'b0;
            state_q   <= StIoDone;
          end else if (wait_cnt_q == TimeoutCnt) begin
            io_data_q <= 8'hFF;
            io_req_q  <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= StIoDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cpu_di = 8'hFF;
    unique case (rsel_q)
      SelRam:  cpu_di = ram_rdata;
      SelIo:   cpu_di = io_data_q;
      default: cpu_di = 8'hFF;
    endcase
  end

  assign cpu_rdy   = (state_q != StIoWait);
  assign ram_addr  = cpu_a[RAM_AW-1:0];
  assign ram_wdata = cpu_do;
  assign ram_we    = cpu_we & ram_hit & cpu_rdy & ~reset;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: a behavioural RAM and a bench-driven
// I/O target surround the DUT; expectations come from a region-level model.

module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [11:0] io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic        bus_err;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  int         npass   = 0;
  int         nchecks = 0;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_a     (cpu_a),
    .cpu_do    (cpu_do),
    .cpu_we    (cpu_we),
    .cpu_di    (cpu_di),
    .cpu_rdy   (cpu_rdy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .bus_err   (bus_err)
  );

  // Environment RAM: synchronous read, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // One core access starting in the current ready cycle (called at posedge+1).
  // ack_after: stall cycle in which the target acks (0 = never).
  // Returns at posedge+1 of the next ready cycle.
  task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input int ack_after, input logic [7:0] iord, input string nm);
    logic       is_ram;
    logic       is_io;
    logic       acked;
    int         stalls;
    int         exp_stall;
    logic [7:0] exp_di;
    is_ram = (a < 16'h1000);
    is_io  = !is_ram && (a[15:12] == 4'hD);
    acked  = is_io && ack_after >= 1 && ack_after <= 255;
    cpu_a  = a;
    cpu_we = we;
    cpu_do = d;
    @(negedge clk);
    nchecks++;
    if (ram_we !== (we && is_ram))
      $display("FAIL %s ram_we: got %b want %b", nm, ram_we, we && is_ram);
    else npass++;
    if (is_ram) begin
      nchecks++;
      if (ram_addr !== a[11:0]) $display("FAIL %s ram_addr: got %h want %h", nm, ram_addr, a[11:0]);
      else npass++;
    end
    @(posedge clk); #1;
    stalls = 0;
    while (cpu_rdy !== 1'b1 && stalls < 300) begin
      stalls++;
      if (stalls == 1) begin
        nchecks++;
        if (io_req !== 1'b1 || io_addr !== a[11:0] || io_we !== we || (we && io_wdata !== d))
          $display("FAIL %s io_request: got req=%b addr=%h we=%b wd=%h want 1 %h %b %h",
                   nm, io_req, io_addr, io_we, io_wdata, a[11:0], we, d);
        else npass++;
      end
      if (stalls == ack_after) begin
        io_ack   = 1'b1;
        io_rdata = iord;
      end
      @(posedge clk); #1;
      io_ack   = 1'b0;
      io_rdata = 8'($urandom);
    end
    exp_stall = !is_io ? 0 : (acked ? ack_after : 255);
    if (is_io && !acked) exp_err = 1'b1;
    nchecks++;
    if (stalls !== exp_stall) $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stall);
    else npass++;
    nchecks++;
    if (io_req !== 1'b0) $display("FAIL %s io_req_after: got %b want 0", nm, io_req);
    else npass++;
    if (!we) begin
      exp_di = is_ram ? ref_mem[a[11:0]] : (acked ? iord : 8'hFF);
      nchecks++;
      if (cpu_di !== exp_di) $display("FAIL %s cpu_di: got %h want %h", nm, cpu_di, exp_di);
      else npass++;
    end
    nchecks++;
    if (bus_err !== exp_err) $display("FAIL %s bus_err: got %b want %b", nm, bus_err, exp_err);
    else npass++;
    if (we && is_ram) ref_mem[a[11:0]] = d;
    cpu_we = 1'b0;
    cpu_a  = 16'h8000;
  endtask

  function automatic logic [15:0] rand_addr(input int region);
    logic [15:0] a;
    case (region)
      0: a = 16'($urandom_range(0, 16'h0FFF));
      1: a = 16'hD000 | 16'($urandom_range(0, 16'h0FFF));
      default: begin
        a = 16'($urandom);
        while (a < 16'h1000 || a[15:12] == 4'hD) a = 16'($urandom);
      end
    endcase
    return a;
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    cpu_a  = 16'h0001;
    cpu_we = 1'b1;
    cpu_do = 8'h77;
    io_ack = 1'b0;
    io_rdata = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    nchecks++;
    if (ram_we !== 1'b0) $display("FAIL reset ram_we: got %b want 0", ram_we);
    else npass++;
    @(posedge clk); #1;
    nchecks++;
    if (cpu_rdy !== 1'b1 || io_req !== 1'b0 || bus_err !== 1'b0 || cpu_di !== 8'hFF)
      $display("FAIL reset outputs: got rdy=%b req=%b err=%b di=%h want 1 0 0 ff",
               cpu_rdy, io_req, bus_err, cpu_di);
    else npass++;
    nchecks++;
    if (io_we !== 1'b0 || io_addr !== 12'h000 || io_wdata !== 8'h00)
      $display("FAIL reset io_regs: got we=%b addr=%h wd=%h want 0 000 00", io_we, io_addr, io_wdata);
    else npass++;
    reset  = 1'b0;
    cpu_we = 1'b0;
    cpu_a  = 16'h8000;
  endtask

  task automatic test_ram();
    do_access(16'h0123, 1'b1, 8'h5A, 0, 8'h00, "ram_wr_0123");
    do_access(16'h0123, 1'b0, 8'h00, 0, 8'h00, "ram_rd_0123");
    do_access(16'h0FFF, 1'b1, 8'h3C, 0, 8'h00, "ram_wr_0fff");
    do_access(16'h1000, 1'b1, 8'hC3, 0, 8'h00, "wr_1000");
    do_access(16'h0FFF, 1'b0, 8'h00, 0, 8'h00, "ram_rd_0fff");
    for (int i = 0; i < 12; i++)
      do_access(rand_addr(0), 1'($urandom), 8'($urandom), 0, 8'h00, "ram_rand");
  endtask

  task automatic test_unmapped();
    do_access(16'h8000, 1'b0, 8'h00, 0, 8'h00, "unm_rd_8000");
    do_access(16'h8000, 1'b1, 8'h11, 0, 8'h00, "unm_wr_8000");
    do_access(16'hFFFF, 1'b0, 8'h00, 0, 8'h00, "unm_rd_ffff");
  endtask

  task automatic test_io();
    do_access(16'hD010, 1'b0, 8'h00, 3, 8'hA7, "io_rd_d010");
    do_access(16'hD020, 1'b0, 8'h00, 1, 8'h3E, "io_rd_min");
    do_access(16'hDFFF, 1'b1, 8'h95, 2, 8'h00, "io_wr_dfff");
    do_access(16'hD001, 1'b0, 8'h00, 255, 8'h6B, "io_ack_at_limit");
    for (int i = 0; i < 8; i++)
      do_access(rand_addr(1), 1'($urandom), 8'($urandom), $urandom_range(1, 6),
                8'($urandom), "io_rand");
  endtask

  task automatic test_timeout();
    do_access(16'hD000, 1'b0, 8'h00, 0, 8'h00, "io_timeout");
    do_access(16'h0123, 1'b0, 8'h00, 0, 8'h00, "err_sticky_ram");
    do_access(16'hD004, 1'b0, 8'h00, 2, 8'h44, "err_sticky_io");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 3);
      do_access(rand_addr(r > 2 ? 2 : (r == 0 ? 0 : 1)), 1'($urandom), 8'($urandom),
                $urandom_range(1, 5), 8'($urandom), "b2b");
    end
  endtask

  task automatic test_reset_mid_io();
    cpu_a  = 16'hD055;
    cpu_we = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    nchecks++;
    if (cpu_rdy !== 1'b0 || io_req !== 1'b1)
      $display("FAIL midio_stalled: got rdy=%b req=%b want 0 1", cpu_rdy, io_req);
    else npass++;
    reset  = 1'b1;
    cpu_a  = 16'h0010;
    cpu_we = 1'b1;
    cpu_do = 8'h99;
    @(negedge clk);
    nchecks++;
    if (ram_we !== 1'b0) $display("FAIL midio_reset_ram_we: got %b want 0", ram_we);
    else npass++;
    @(posedge clk); #1;
    reset  = 1'b0;
    cpu_we = 1'b0;
    cpu_a  = 16'h8000;
    exp_err = 1'b0;
    nchecks++;
    if (io_req !== 1'b0 || cpu_rdy !== 1'b1 || bus_err !== 1'b0 || cpu_di !== 8'hFF)
      $display("FAIL midio_after_reset: got req=%b rdy=%b err=%b di=%h want 0 1 0 ff",
               io_req, cpu_rdy, bus_err, cpu_di);
    else npass++;
    io_ack   = 1'b1;
    io_rdata = 8'h12;
    @(posedge clk); #1;
    io_ack = 1'b0;
    nchecks++;
    if (io_req !== 1'b0 || cpu_rdy !== 1'b1 || cpu_di !== 8'hFF || bus_err !== 1'b0)
      $display("FAIL late_ack: got req=%b rdy=%b di=%h err=%b want 0 1 ff 0",
               io_req, cpu_rdy, cpu_di, bus_err);
    else npass++;
    do_access(16'h0010, 1'b0, 8'h00, 0, 8'h00, "ram_after_reset");
    do_access(16'hD100, 1'b0, 8'h00, 2, 8'h5C, "io_after_reset");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_ram();
    test_unmapped();
    test_io();
    test_timeout();
    test_back_to_back();
    test_reset_mid_io();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
